// File: rtl/imem_loader_if.sv
// Byte-stream link into the loader plus the instruction-memory write port it drives.
interface imem_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a framed big-endian image (len, words, xor checksum) into instruction memory,
// holding the core stalled until a good image is in place.
module imem_loader #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    imem_loader_if.slave bus,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t        state, state_nx;
    logic [7:0]    len_hi;
    logic [7:0]    csum;
    logic [15:0]   n_words;
    logic [1:0]    bcnt;
    logic [23:0]   sh;
    logic [CW-1:0] wcnt;
    logic [31:0]   wr_addr_q, wr_data_q;

    logic          accept, can_start, oversize, last_word, csum_ok;
    logic [15:0]   n_rx;

    assign accept    = bus.byte_valid && bus.byte_ready;
    assign can_start = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign n_rx      = {len_hi, bus.byte_in};
    assign oversize  = n_rx > 16'(DEPTH);
    // wcnt still holds the count before the word being written this cycle
    assign last_word = (16'(wcnt) + 16'd1) >= n_words;
    assign csum_ok   = bus.byte_in == csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        bus.byte_ready = 1'b0;
        bus.wr_en      = 1'b0;
        cpu_hold       = 1'b1;
        case (state)
            S_IDLE, S_DONE: begin
                cpu_hold = 1'b0;
                if (start) state_nx = S_LEN_HI;
            end
            S_ERR: begin
                if (start) state_nx = S_LEN_HI;
            end
            S_LEN_HI: begin
                bus.byte_ready = 1'b1;
                if (accept) state_nx = S_LEN_LO;
            end
            S_LEN_LO: begin
                bus.byte_ready = 1'b1;
                if (accept) begin
                    if (oversize)          state_nx = S_ERR;
                    else if (n_rx == '0)   state_nx = S_CSUM;
                    else                   state_nx = S_DATA;
                end
            end
            S_DATA: begin
                bus.byte_ready = 1'b1;
                if (accept && bcnt == 2'd3) state_nx = S_WRITE;
            end
            S_WRITE: begin
                bus.wr_en = 1'b1;
                state_nx  = last_word ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                bus.byte_ready = 1'b1;
                if (accept) state_nx = csum_ok ? S_DONE : S_ERR;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_hi    <= '0;
            csum      <= '0;
            n_words   <= '0;
            bcnt      <= '0;
            sh        <= '0;
            wcnt      <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            if (can_start) begin
                done      <= 1'b0;
                error     <= 1'b0;
                csum      <= '0;
                bcnt      <= '0;
                wcnt      <= '0;
                wr_addr_q <= '0;
            end
            if (accept) begin
                csum <= csum ^ bus.byte_in;
                case (state)
                    S_LEN_HI: len_hi <= bus.byte_in;
                    S_LEN_LO: begin
                        n_words <= n_rx;
                        if (oversize) error <= 1'b1;
                    end
                    S_DATA: begin
                        bcnt <= bcnt + 2'd1;
                        sh   <= {sh[15:0], bus.byte_in};
                        // address/data are latched together so both hold until the next write
                        if (bcnt == 2'd3) begin
                            wr_data_q <= {sh, bus.byte_in};
                            wr_addr_q <= 32'(wcnt);
                        end
                    end
                    S_CSUM: begin
                        if (csum_ok) done  <= 1'b1;
                        else         error <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (state == S_WRITE) wcnt <= wcnt + 1'b1;
        end
    end

    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the instruction memory over a byte-stream link before the core runs. It receives a framed image (length, big-endian instruction words, checksum), assembles each 32-bit word and issues one write per word at consecutive word addresses from 0. It holds the core stalled while loading and reports completion or a framing/checksum error. It is the write-side counterpart of the instruction memory's combinational read port.

## Interface
- DEPTH, 256: instruction memory entries; a word count above DEPTH is an error.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- byte_in  input  8  stream data.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte; a transfer occurs when byte_valid && byte_ready.
- wr_en  output  1  one-cycle write strobe to the instruction memory.
- wr_addr  output  32  word address of the write, from 0 to N-1.
- wr_data  output  32  assembled instruction word.
- cpu_hold  output  1  stalls the core while a load is active.
- done  output  1  sticky; the last load completed with a good checksum.
- error  output  1  sticky; the last load was aborted.

## Operation
- Frame: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N×4 data bytes (each word MSB first), then CSUM.
- CSUM is the 8-bit XOR of every preceding frame byte, including both length bytes.
- States:
  - IDLE: waiting for start.
  - LEN_HI, LEN_LO: capture N.
  - DATA: shift bytes into the word register; 2-bit byte counter.
  - WRITE: one cycle; asserts wr_en.
  - CSUM: compare the received checksum.
  - DONE, ERR: terminal until the next start.
- Transitions:
  - IDLE/DONE/ERR + start → LEN_HI. This clears done, error, the running XOR, the word counter and the address.
  - LEN_LO accept: if N > DEPTH → ERR. If N == 0 → CSUM. Otherwise → DATA.
  - DATA: on the 4th accepted byte → WRITE.
  - WRITE → DATA if the words written so far (including this one) < N, otherwise → CSUM. The address increments after each write.
  - CSUM accept: match → DONE (done=1); mismatch → ERR (error=1).
- start while in LEN_HI..CSUM is ignored.
- byte_ready is 1 in LEN_HI, LEN_LO, DATA and CSUM, and 0 in IDLE, WRITE, DONE and ERR.
- cpu_hold is 1 in every state from LEN_HI through CSUM, 0 in IDLE and DONE, and 1 in ERR. A bad image never runs.
- Bytes presented while byte_ready=0 are not consumed.
- A word is never partially written. Words already written before an error are left in memory.
- Width rules:
  - wr_addr is the zero-extended word counter (counter width clog2(DEPTH)+1).
  - N is compared as an unsigned 16-bit value.

## Timing
- Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, error=0; state IDLE.
- Reset asserted mid-load returns to IDLE immediately. No further writes are issued, and partial contents are left in memory.
- Throughput: at most one byte per cycle; each word costs 4 accept cycles plus 1 WRITE cycle.
- wr_en is high for exactly the WRITE cycle. wr_addr and wr_data are valid in that cycle and hold until the next write.
- Minimum load of N words with no stall: 3 + 5N cycles from the first LEN_HI accept to done=1.
  - done, or error on a checksum failure, rises the cycle after the CSUM accept.
  - On an oversize count, error rises the cycle after the LEN_LO accept.
- cpu_hold rises the cycle after start and falls the same cycle done rises.
- Gaps in byte_valid only stall the FSM and never change the result.

## Test plan
- Good 2-word load: after start, send 00 02 68 00 00 00 4C 40 00 00 66 back-to-back. Required: wr_en at addr 0 with 0x68000000, then at addr 1 with 0x4C400000; done=1; cpu_hold=0; 13 cycles from the first accept to done.
- Zero count: send 00 00 00 → no wr_en, done=1. Sending 00 00 01 instead → error=1, cpu_hold=1.
- Oversize: send 01 01 (N=257) → error=1 the cycle after the second byte; byte_ready=0; no writes.
- Bad checksum: the 2-word frame with a final byte of 0x67 → both writes occur, error=1, done=0, cpu_hold=1. A new start followed by a good frame → error=0, then done=1.
- Backpressure/start: random byte_valid gaps plus a start pulse during DATA → identical writes and done timing shifted only by the gaps.
- Reset mid-load: assert rst_n=0 after the 6th byte of the good frame → all outputs return to reset values asynchronously; exactly one write occurred; after release the state is IDLE.
